event_rate_monitor: RTL and testbench
=====================================

Name: event_rate_monitor

Overview:
- Multi-channel, window-based event counter. Counts qualifying events on NUM_CH single-bit inputs over a programmable window of clk cycles.
- At each window end it publishes per-channel counts, saturation flags and limit alarms.
- Stops itself after a programmable number of windows.
- Used in test benches and debug logic to measure relative rates of strobes and clocks that are already synchronised to clk. It generalises the fixed two-counter ratio check to N channels, a configurable window, edge/level modes and self-checking limits.

Parameters:
- NUM_CH, 4, number of monitored channels (1..16)
- CNT_W, 32, per-channel count width
- WIN_W, 16, width of window_len and num_windows
- EDGE_MODE, 1, 1 = count 0->1 transitions, 0 = count cycles where input is high

Ports:
- clk  input  1  single clock; all logic on posedge
- reset  input  1  asynchronous, active-high reset
- start  input  1  pulse; begin measurement (from IDLE or DONE)
- stop  input  1  pulse; abort measurement
- window_len  input  WIN_W  window length in cycles; sampled at start; 0 = start ignored
- num_windows  input  WIN_W  windows to run; sampled at start; 0 = run until stop
- limit  input  CNT_W  alarm threshold, compared at publish
- event_i  input  NUM_CH  event inputs, synchronous to clk
- count_o  output  NUM_CH*CNT_W  last published counts, channel 0 in LSBs
- sat_o  output  NUM_CH  channel saturated in last published window
- alarm_o  output  NUM_CH  sticky: channel count exceeded limit in any window since start
- result_valid  output  1  one-cycle pulse when count_o/sat_o update
- window_idx  output  WIN_W  number of windows published since start
- busy  output  1  high in RUN
- done  output  1  high in DONE

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, accumulators 0, edge history register 0.
- States: IDLE, RUN, DONE. The enum lives in the package.
- IDLE/DONE + start with window_len != 0 -> RUN.
  - Load window countdown = window_len-1.
  - Clear accumulators, alarm_o and window_idx.
  - Latch window_len and num_windows.
- IDLE/DONE + start with window_len == 0: no effect.
- Edge history register samples event_i every cycle in every state. In edge mode this gives a correct first RUN cycle.
- RUN, every cycle, per channel: if the event qualifies, the accumulator increments.
  - Increment saturates at 2^CNT_W-1.
  - A per-channel sat bit is set if an increment is attempted at max.
- Window end: the cycle where countdown == 0.
  - Events in that cycle are included.
  - Next cycle: count_o <= accumulator values, sat_o <= sat bits, result_valid = 1, window_idx += 1.
  - alarm_o[i] |= (count > limit).
  - Accumulators and sat bits restart from 0 with no gap; the cycle after the window end is the first cycle of the next window.
  - Latency from last sampled cycle to result_valid: 1 cycle.
- After publishing, if num_windows != 0 and window_idx == num_windows: RUN -> DONE in the same cycle as result_valid.
- DONE: count_o, sat_o, alarm_o and window_idx hold; done = 1. start restarts as from IDLE.
- stop in RUN: -> IDLE next cycle. The partial window is discarded, count_o holds its previous value and no result_valid is issued.
- stop and window end in the same cycle: the window is published, then -> IDLE.
- stop in IDLE/DONE: no effect. In DONE, stop and start in the same cycle: start wins.
- start while in RUN: ignored.
- Window length 1: every cycle is a window end, so result_valid is high continuously.
- window_idx wraps at 2^WIN_W-1 -> 0 only when num_windows == 0.
- Embedded checks, simulation only:
  - Assertion: result_valid is never high in IDLE.
  - Cover point: a window where every channel count is nonzero.

Decomposition:
- Package event_rate_monitor_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - a per-channel result struct {count, sat}
- Sub-module rate_chan_cnt, one instance per channel via generate. It contains:
  - edge/level qualification
  - the saturating accumulator and sat bit
  - the published-count register and the alarm compare
- The top level holds the FSM, window countdown and window_idx.

Test Plan:
- EDGE_MODE=1, NUM_CH=4, window_len=10, num_windows=0, ch0 toggles every cycle, ch1 every 2 cycles -> first result_valid 11 cycles after start; count ch0=5, ch1=2 (or 3, depending on phase; check exactly against the bench model); ch2/ch3=0.
- EDGE_MODE=0, CNT_W=4, window_len=20, ch0 held high -> count 15, sat_o[0]=1; next window the same; ch1 low -> 0, sat 0.
- window_len=8, num_windows=3, ch0 high, level mode -> exactly 3 result_valid pulses 8 cycles apart, each count 8; done=1 on the third pulse; window_idx=3 holds.
- stop on the 5th cycle of the first window -> no result_valid, busy=0 next cycle, count_o stays 0. Repeat with stop on the window-end cycle -> one publish, then IDLE.
- limit=7, level mode, ch2 high for exactly 8 cycles of a 10-cycle window -> alarm_o[2]=1, stays set through later zero-count windows; next start clears it.
- reset asserted mid-window, asynchronously between clock edges -> all outputs 0 immediately. After release, start runs normally and its first window count is correct.

Source files
------------

// File: rtl/event_rate_monitor_pkg.sv
// Shared types for the event rate monitor.
// Holds the FSM state enum and the per-channel result bundle.
package event_rate_monitor_pkg;

  localparam int MAX_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [MAX_CNT_W-1:0] count;
    logic                 sat;
  } chan_res_t;

endpackage

// File: rtl/rate_chan_cnt.sv
// One monitored channel: qualify, accumulate with saturation,
// publish at window end and track the sticky limit alarm.
module rate_chan_cnt
  import event_rate_monitor_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int EDGE_MODE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_run,
  input  logic             i_pub,
  input  logic             i_event,
  input  logic [CNT_W-1:0] i_limit,
  output chan_res_t        o_res,
  output logic             o_alarm
);

  logic             r_prev;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic             r_sat_pub;
  logic             r_alarm;

  logic             w_qual;
  logic             w_inc;
  logic             w_max;
  logic [CNT_W-1:0] w_acc_nxt;
  logic             w_sat_nxt;

  assign w_qual    = (EDGE_MODE != 0) ? (i_event & ~r_prev) : i_event;
  assign w_inc     = i_run & w_qual;
  assign w_max     = &r_acc;
  assign w_acc_nxt = (w_inc && !w_max) ? r_acc + 1'b1 : r_acc;
  assign w_sat_nxt = r_sat | (w_inc & w_max);

  // Edge history follows the input every cycle, in every state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= i_event;
  end

  // Accumulate, then publish and restart with no gap at window end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
      r_sat_pub <= 1'b0;
      r_alarm   <= 1'b0;
    end else if (i_clr) begin
      r_acc   <= '0;
      r_sat   <= 1'b0;
      r_alarm <= 1'b0;
    end else if (i_pub) begin
      r_cnt     <= w_acc_nxt;
      r_sat_pub <= w_sat_nxt;
      r_alarm   <= r_alarm | (w_acc_nxt > i_limit);
      r_acc     <= '0;
      r_sat     <= 1'b0;
    end else if (i_run) begin
      r_acc <= w_acc_nxt;
      r_sat <= w_sat_nxt;
    end
  end

  assign o_res.count = MAX_CNT_W'(r_cnt);
  assign o_res.sat   = r_sat_pub;
  assign o_alarm     = r_alarm;

endmodule

// File: rtl/event_rate_monitor.sv
// Window-based multi-channel event counter with limit alarms.
// FSM, window countdown and window index live here.
module event_rate_monitor
  import event_rate_monitor_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 32,
  parameter int WIN_W     = 16,
  parameter int EDGE_MODE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic [WIN_W-1:0]        window_len,
  input  logic [WIN_W-1:0]        num_windows,
  input  logic [CNT_W-1:0]        limit,
  input  logic [NUM_CH-1:0]       event_i,
  output logic [NUM_CH*CNT_W-1:0] count_o,
  output logic [NUM_CH-1:0]       sat_o,
  output logic [NUM_CH-1:0]       alarm_o,
  output logic                    result_valid,
  output logic [WIN_W-1:0]        window_idx,
  output logic                    busy,
  output logic                    done
);

  state_t           r_state;
  logic [WIN_W-1:0] r_cd;
  logic [WIN_W-1:0] r_len;
  logic [WIN_W-1:0] r_nw;
  logic [WIN_W-1:0] r_idx;
  logic             r_pend;
  logic             r_rv;

  logic             w_go;
  logic             w_cnt_en;
  logic             w_end;
  logic             w_last;
  logic [WIN_W-1:0] w_idx_nxt;
  chan_res_t        w_res [NUM_CH];
  logic [NUM_CH-1:0] w_nz;

  assign w_go      = (r_state != RUN) && start && (window_len != '0);
  assign w_cnt_en  = (r_state == RUN) && !r_pend;
  assign w_end     = w_cnt_en && (r_cd == '0);
  assign w_idx_nxt = r_idx + 1'b1;
  assign w_last    = (r_nw != '0) && (w_idx_nxt == r_nw);

  // Control FSM; a stop on a window end publishes first, idles next
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cd    <= '0;
      r_len   <= '0;
      r_nw    <= '0;
      r_idx   <= '0;
      r_pend  <= 1'b0;
      r_rv    <= 1'b0;
    end else begin
      r_rv <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_go) begin
            r_state <= RUN;
            r_cd    <= window_len - 1'b1;
            r_len   <= window_len;
            r_nw    <= num_windows;
            r_idx   <= '0;
            r_pend  <= 1'b0;
          end
        end
        RUN: begin
          if (r_pend) begin
            r_state <= IDLE;
            r_pend  <= 1'b0;
          end else if (w_end) begin
            r_rv  <= 1'b1;
            r_idx <= w_idx_nxt;
            r_cd  <= r_len - 1'b1;
            if (w_last)    r_state <= DONE;
            else if (stop) r_pend  <= 1'b1;
          end else begin
            r_cd <= r_cd - 1'b1;
            if (stop) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rate_chan_cnt #(
      .CNT_W     (CNT_W),
      .EDGE_MODE (EDGE_MODE)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (w_go),
      .i_run   (w_cnt_en),
      .i_pub   (w_end),
      .i_event (event_i[g]),
      .i_limit (limit),
      .o_res   (w_res[g]),
      .o_alarm (alarm_o[g])
    );
    assign count_o[g*CNT_W +: CNT_W] = w_res[g].count[CNT_W-1:0];
    assign sat_o[g] = w_res[g].sat;
    assign w_nz[g]  = |w_res[g].count;
  end

  assign result_valid = r_rv;
  assign window_idx   = r_idx;
  assign busy         = (r_state == RUN);
  assign done         = (r_state == DONE);

`ifndef SYNTHESIS
  a_no_rv_idle : assert property (
    @(posedge clk) disable iff (reset)
    !(result_valid && r_state == IDLE));
  c_all_nz : cover property (
    @(posedge clk) disable iff (reset)
    result_valid && (&w_nz));
`endif

endmodule

// File: tb/tb_event_rate_monitor.sv
// Self-checking bench: edge-mode 32-bit and level-mode 4-bit
// instances share stimulus and are compared to a window model.
module tb_event_rate_monitor;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, stop;
  logic [15:0]  window_len, num_windows;
  logic [31:0]  limit;
  logic [3:0]   lim_l;
  logic [3:0]   event_i;

  logic [127:0] cnt_e;
  logic [15:0]  cnt_l;
  logic [3:0]   sat_e, sat_l, alm_e, alm_l;
  logic         rv_e, rv_l, busy_e, busy_l, done_e, done_l;
  logic [15:0]  idx_e, idx_l;

  int n_chk = 0;
  int n_fail = 0;

  assign lim_l = limit[3:0];

  always #5 clk = ~clk;

  event_rate_monitor #(
    .NUM_CH(4), .CNT_W(32), .WIN_W(16), .EDGE_MODE(1)
  ) u_e (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .window_len(window_len), .num_windows(num_windows),
    .limit(limit), .event_i(event_i), .count_o(cnt_e),
    .sat_o(sat_e), .alarm_o(alm_e), .result_valid(rv_e),
    .window_idx(idx_e), .busy(busy_e), .done(done_e)
  );

  event_rate_monitor #(
    .NUM_CH(4), .CNT_W(4), .WIN_W(16), .EDGE_MODE(0)
  ) u_l (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .window_len(window_len), .num_windows(num_windows),
    .limit(lim_l), .event_i(event_i), .count_o(cnt_l),
    .sat_o(sat_l), .alarm_o(alm_l), .result_valid(rv_l),
    .window_idx(idx_l), .busy(busy_l), .done(done_l)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running, 2 finished
  int          m_mode, m_pos, m_len;
  logic [15:0] m_nw;
  bit          m_pend;
  logic [3:0]  m_prev;
  longint      raw_e [4];
  longint      raw_l [4];
  logic [31:0] x_ce [4];
  logic [3:0]  x_cl [4];
  logic [3:0]  x_se, x_sl, x_ae, x_al;
  logic        x_rv;
  logic [15:0] x_idx;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_pos = 0; m_len = 0; m_nw = 0; m_pend = 0;
      m_prev = 0; x_se = 0; x_sl = 0; x_ae = 0; x_al = 0;
      x_rv = 0; x_idx = 0;
      for (int c = 0; c < 4; c++) begin
        raw_e[c] = 0; raw_l[c] = 0; x_ce[c] = 0; x_cl[c] = 0;
      end
    end else begin
      x_rv = 0;
      if (m_mode == 1) begin
        if (m_pend) begin
          m_mode = 0;
          m_pend = 0;
        end else begin
          for (int c = 0; c < 4; c++) begin
            if (event_i[c] && !m_prev[c]) raw_e[c]++;
            if (event_i[c]) raw_l[c]++;
          end
          m_pos++;
          if (m_pos == m_len) begin
            for (int c = 0; c < 4; c++) begin
              x_se[c] = raw_e[c] > 64'hFFFF_FFFF;
              x_ce[c] = x_se[c] ? 32'hFFFF_FFFF : raw_e[c][31:0];
              x_sl[c] = raw_l[c] > 15;
              x_cl[c] = x_sl[c] ? 4'hF : raw_l[c][3:0];
              if (x_ce[c] > limit) x_ae[c] = 1'b1;
              if (x_cl[c] > limit[3:0]) x_al[c] = 1'b1;
              raw_e[c] = 0;
              raw_l[c] = 0;
            end
            x_rv = 1;
            x_idx = x_idx + 16'd1;
            m_pos = 0;
            if (m_nw != 0 && x_idx == m_nw) m_mode = 2;
            else if (stop) m_pend = 1;
          end else if (stop) begin
            m_mode = 0;
          end
        end
      end else if (start && window_len != 0) begin
        m_mode = 1; m_pos = 0; m_len = window_len;
        m_nw = num_windows; m_pend = 0;
        x_ae = 0; x_al = 0; x_idx = 0;
        for (int c = 0; c < 4; c++) begin
          raw_e[c] = 0; raw_l[c] = 0;
        end
      end
      m_prev = event_i;
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (!reset) begin
      logic [127:0] ce;
      logic [15:0]  cl;
      for (int c = 0; c < 4; c++) begin
        ce[c*32 +: 32] = x_ce[c];
        cl[c*4 +: 4]   = x_cl[c];
      end
      chk("cnt_e", cnt_e, ce);
      chk("cnt_l", 128'(cnt_l), 128'(cl));
      chk("sat_e", 128'(sat_e), 128'(x_se));
      chk("sat_l", 128'(sat_l), 128'(x_sl));
      chk("alm_e", 128'(alm_e), 128'(x_ae));
      chk("alm_l", 128'(alm_l), 128'(x_al));
      chk("rv_e", 128'(rv_e), 128'(x_rv));
      chk("rv_l", 128'(rv_l), 128'(x_rv));
      chk("idx_e", 128'(idx_e), 128'(x_idx));
      chk("idx_l", 128'(idx_l), 128'(x_idx));
      chk("busy_e", 128'(busy_e), 128'(m_mode == 1));
      chk("busy_l", 128'(busy_l), 128'(m_mode == 1));
      chk("done_e", 128'(done_e), 128'(m_mode == 2));
      chk("done_l", 128'(done_l), 128'(m_mode == 2));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start(input int wl, input int nw);
    @(negedge clk);
    window_len  = 16'(wl);
    num_windows = 16'(nw);
    start       = 1'b1;
  endtask

  task automatic do_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_cnt"}, cnt_e | 128'(cnt_l), 128'd0);
    chk({nm, "_flags"},
        128'({sat_e, sat_l, alm_e, alm_l, rv_e, rv_l,
              busy_e, busy_l, done_e, done_l, idx_e, idx_l}),
        128'd0);
  endtask

  initial begin
    int first, nrv, last;
    logic [31:0] c0, c2;

    reset = 1'b1; start = 0; stop = 0; window_len = 0;
    num_windows = 0; limit = '1; event_i = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // edge mode: ch0 toggles each cycle, ch1 every 2 cycles
    pulse_start(10, 0);
    first = 0; c0 = 0; c2 = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start = 0;
      if (rv_e && first == 0) begin
        first = k;
        c0 = cnt_e[31:0];
        c2 = cnt_e[95:64];
      end
      event_i[0] = ~event_i[0];
      if (k % 2 == 0) event_i[1] = ~event_i[1];
    end
    chk("t1_latency", 128'(first), 128'd11);
    chk("t1_ch0", 128'(c0), 128'd5);
    chk("t1_ch2", 128'(c2), 128'd0);
    do_stop();

    // level mode saturation on the 4-bit instance
    event_i = 4'b0001;
    pulse_start(20, 0);
    nrv = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      start = 0;
      if (rv_l) begin
        nrv++;
        chk("t2_cnt0", 128'(cnt_l[3:0]), 128'd15);
        chk("t2_sat0", 128'(sat_l[0]), 128'd1);
        chk("t2_cnt1", 128'(cnt_l[7:4]), 128'd0);
        chk("t2_sat1", 128'(sat_l[1]), 128'd0);
      end
    end
    chk("t2_pulses", 128'(nrv), 128'd2);
    do_stop();

    // bounded run of three windows
    pulse_start(8, 3);
    nrv = 0; last = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 0;
      if (rv_l) begin
        nrv++;
        if (nrv > 1) chk("t3_gap", 128'(k - last), 128'd8);
        last = k;
        chk("t3_cnt", 128'(cnt_l[3:0]), 128'd8);
        if (nrv == 3) chk("t3_done", 128'(done_l), 128'd1);
      end
    end
    chk("t3_pulses", 128'(nrv), 128'd3);
    chk("t3_idx", 128'(idx_l), 128'd3);
    chk("t3_hold", 128'(done_l), 128'd1);

    // stop on 5th cycle of first window
    do_reset();
    pulse_start(10, 0);
    nrv = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 0;
      stop = (k == 5);
      if (k == 6) chk("t4_busy", 128'(busy_l), 128'd0);
      if (rv_l) nrv++;
    end
    chk("t4_norv", 128'(nrv), 128'd0);
    chk("t4_cnt", 128'(cnt_l), 128'd0);

    // stop on the window-end cycle
    pulse_start(10, 0);
    nrv = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 0;
      stop = (k == 10);
      if (rv_l) nrv++;
    end
    chk("t4b_rv", 128'(nrv), 128'd1);
    chk("t4b_cnt", 128'(cnt_l[3:0]), 128'd10);
    chk("t4b_busy", 128'(busy_l), 128'd0);

    // sticky alarm
    event_i = 0;
    limit = 32'd7;
    pulse_start(10, 0);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      start = 0;
      if (k == 11) begin
        chk("t5_alarm", 128'(alm_l[2]), 128'd1);
        chk("t5_cnt", 128'(cnt_l[11:8]), 128'd8);
      end
      event_i[2] = (k <= 8);
    end
    chk("t5_sticky", 128'(alm_l[2]), 128'd1);
    do_stop();
    pulse_start(10, 0);
    @(negedge clk);
    start = 0;
    chk("t5_clear", 128'(alm_l), 128'd0);

    // asynchronous reset between edges
    event_i = 4'b1111;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_all_zero("t6_async");
    @(negedge clk);
    reset = 1'b0;
    event_i = 4'b0001;
    pulse_start(6, 0);
    nrv = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 0;
      if (rv_l && nrv == 0) begin
        nrv++;
        chk("t6_cnt", 128'(cnt_l[3:0]), 128'd6);
      end
    end
    chk("t6_seen", 128'(nrv), 128'd1);
    do_stop();

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      event_i     = 4'($urandom);
      start       = ($urandom % 16) == 0;
      stop        = ($urandom % 40) == 0;
      window_len  = 16'($urandom_range(0, 24));
      num_windows = 16'($urandom_range(0, 4));
      limit       = 32'($urandom_range(0, 12));
    end
    start = 0;
    stop = 0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
